pr_bram_arbiter: RTL

Shares the single-port image BRAM (15-bit address, 96-bit word, 18400 words) between the three partial-reconfiguration regions. It replaces the free-running address counter in front of the BRAM. Each region issues its own read requests through a valid/ready handshake; the block round-robin arbitrates them, drives the BRAM port, and returns each read word tagged to its requester at a fixed latency. It sits between the PR regions and the BRAM in the pixel-clock domain.

---
 rtl/pr_bram_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 44 ++++
 rtl/pr_bram_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pr_bram_pkg.sv
// Shared constants and the response tag for the PR-region BRAM read arbiter.
package pr_bram_pkg;

    localparam int N_REQ  = 3;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 96;
    localparam int DEPTH  = 18400;
    localparam int RD_LAT = 1;
    localparam int IDX_W  = $clog2(N_REQ);

    typedef struct packed {
        logic [N_REQ-1:0] owner;
        logic             err;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over N_REQ requesters; owns the last_grant pointer,
// which moves only when the parent accepts the granted transfer.
module rr_arbiter
    import pr_bram_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_advance,
    output logic [N_REQ-1:0] o_grant
);

    logic [IDX_W-1:0] r_last;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_grant_idx;
    logic             w_found;

    // Search starts one past the last winner and wraps.
    always_comb begin
        o_grant     = '0;
        w_idx       = '0;
        w_grant_idx = r_last;
        w_found     = 1'b0;
        for (int off = 1; off <= N_REQ; off++) begin
            w_idx = IDX_W'((int'(r_last) + off) % N_REQ);
            if (!w_found && i_req[w_idx]) begin
                w_found     = 1'b1;
                w_grant_idx = w_idx;
            end
        end
        if (w_found) begin
            o_grant[w_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= IDX_W'(N_REQ - 1);
        end else if (i_advance && w_found) begin
            r_last <= w_grant_idx;
        end
    end

endmodule

// File: rtl/pr_bram_arbiter.sv
// Shares the single-port image BRAM between the PR regions: round-robin reads,
// fixed-latency tagged responses. PR_BRAM_WRITE_EN adds a priority write port.
module pr_bram_arbiter
    import pr_bram_pkg::*;
#(
    parameter int RD_LAT = pr_bram_pkg::RD_LAT
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_REQ-1:0]        i_req_valid,
    input  logic [N_REQ*ADDR_W-1:0] i_req_addr,
    output logic [N_REQ-1:0]        o_req_ready,
    output logic [N_REQ-1:0]        o_rsp_valid,
    output logic [DATA_W-1:0]       o_rsp_data,
    output logic                    o_rsp_err,
`ifdef PR_BRAM_WRITE_EN
    input  logic                    i_wr_valid,
    output logic                    o_wr_ready,
    input  logic [ADDR_W-1:0]       i_wr_addr,
    input  logic [DATA_W-1:0]       i_wr_data,
`endif
    output logic                    o_bram_en,
    output logic                    o_bram_we,
    output logic [ADDR_W-1:0]       o_bram_addr,
    output logic [DATA_W-1:0]       o_bram_din,
    input  logic [DATA_W-1:0]       i_bram_dout
);

    logic                 w_wr_sel;
    logic [N_REQ-1:0]     w_req;
    logic [N_REQ-1:0]     w_grant;
    logic                 w_rd_acc;
    logic [ADDR_W-1:0]    w_rd_addr;
    logic                 w_rd_in_range;
    tag_t                 w_new_tag;
    tag_t                 w_out_tag;

    tag_t [RD_LAT:0]      r_tag_pipe;
    logic                 r_bram_en;
    logic [ADDR_W-1:0]    r_bram_addr;
    logic [N_REQ-1:0]     r_rsp_valid;
    logic [DATA_W-1:0]    r_rsp_data;
    logic                 r_rsp_err;

`ifdef PR_BRAM_WRITE_EN
    logic                 w_wr_in_range;
    logic                 r_bram_we;
    logic [DATA_W-1:0]    r_bram_din;

    assign w_wr_sel      = i_wr_valid & i_rst_n;
    assign w_wr_in_range = int'(i_wr_addr) < DEPTH;
    assign o_wr_ready    = w_wr_sel;
    assign o_bram_we     = r_bram_we;
    assign o_bram_din    = r_bram_din;
`else
    assign w_wr_sel      = 1'b0;
    assign o_bram_we     = 1'b0;
    assign o_bram_din    = '0;
`endif

    // Reads are masked while a write is pending or reset is held.
    assign w_req = (w_wr_sel || !i_rst_n) ? '0 : i_req_valid;

    rr_arbiter u_rr (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req     (w_req),
        .i_advance (w_rd_acc),
        .o_grant   (w_grant)
    );

    assign o_req_ready = w_grant;
    assign w_rd_acc    = |w_grant;

    always_comb begin
        w_rd_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_rd_addr = i_req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign w_rd_in_range = int'(w_rd_addr) < DEPTH;

    always_comb begin
        w_new_tag = '0;
        if (w_rd_acc) begin
            w_new_tag.owner = w_grant;
            w_new_tag.err   = !w_rd_in_range;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bram_en   <= 1'b0;
            r_bram_addr <= '0;
`ifdef PR_BRAM_WRITE_EN
            r_bram_we   <= 1'b0;
            r_bram_din  <= '0;
`endif
        end else begin
            r_bram_en <= w_rd_acc & w_rd_in_range;
            if (w_rd_acc && w_rd_in_range) begin
                r_bram_addr <= w_rd_addr;
            end
`ifdef PR_BRAM_WRITE_EN
            r_bram_we <= 1'b0;
            if (w_wr_sel) begin
                r_bram_en <= w_wr_in_range;
                r_bram_we <= w_wr_in_range;
                if (w_wr_in_range) begin
                    r_bram_addr <= i_wr_addr;
                    r_bram_din  <= i_wr_data;
                end
            end
`endif
        end
    end

    // Tag leaves the pipe exactly when the BRAM word for it is on i_bram_dout.
    assign w_out_tag = r_tag_pipe[RD_LAT];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tag_pipe  <= '0;
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_tag_pipe  <= {r_tag_pipe[RD_LAT-1:0], w_new_tag};
            r_rsp_valid <= w_out_tag.owner;
            r_rsp_err   <= w_out_tag.err;
            r_rsp_data  <= (|w_out_tag.owner && !w_out_tag.err) ? i_bram_dout : '0;
        end
    end

    assign o_bram_en   = r_bram_en;
    assign o_bram_addr = r_bram_addr;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_err   = r_rsp_err;

endmodule
